// File: rtl/flag_unit8_pkg.sv
// Shared flag-unit definitions: flag bit positions, branch condition codes and
// the condition truth table used by the flag unit and the control decoder.
package flag_unit8_pkg;

  localparam int FLAG_W = 4;
  localparam int COND_W = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_C      = 3'b011,
    COND_NC     = 3'b100,
    COND_N      = 3'b101,
    COND_V      = 3'b110,
    COND_HI     = 3'b111
  } cond_e;

  // One bit per condition code, indexed by the code itself, so a plain
  // mux on cond selects the answer.
  function automatic logic [7:0] cond_table(input logic [FLAG_W-1:0] f);
    logic [7:0] t;
    t          = '0;
    t[COND_ALWAYS] = 1'b1;
    t[COND_Z]  = f[FLAG_Z];
    t[COND_NZ] = ~f[FLAG_Z];
    t[COND_C]  = f[FLAG_C];
    t[COND_NC] = ~f[FLAG_C];
    t[COND_N]  = f[FLAG_N];
    t[COND_V]  = f[FLAG_V];
    t[COND_HI] = f[FLAG_C] & ~f[FLAG_Z];
    return t;
  endfunction

endpackage

// File: rtl/flag_unit8_zero_detect8.sv
// 8-input NOR built as a balanced OR tree followed by a single inverter.
module zero_detect8 (
  input  logic [7:0] data,
  output logic       zero
);

  logic [3:0] or_l1;
  logic [1:0] or_l2;
  logic       or_l3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_l1
      or u_or1 (or_l1[gi], data[2*gi], data[2*gi+1]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_l2
      or u_or2 (or_l2[gi], or_l1[2*gi], or_l1[2*gi+1]);
    end
  endgenerate

  or  u_or3 (or_l3, or_l2[0], or_l2[1]);
  not u_inv (zero, or_l3);

endmodule

// File: rtl/flag_unit8.sv
// Flag register for the 8-bit ALU result bus with sticky multi-byte Z and
// a branch condition evaluator on the latched flags.
module flag_unit8
  import flag_unit8_pkg::*;
#(
  parameter logic [FLAG_W-1:0] RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        result,
  input  logic              carry_in,
  input  logic              ovf_in,
  input  logic              update,
  input  logic              chain,
  input  logic              load,
  input  logic [FLAG_W-1:0] load_data,
  input  logic [COND_W-1:0] cond,
  output logic [FLAG_W-1:0] flags,
  output logic              cond_true,
  output logic              zero_now
);

  logic              zero_det;
  logic [FLAG_W-1:0] upd_val;
  logic [FLAG_W-1:0] flags_reg;
  logic [FLAG_W-1:0] flags_next;
  logic [FLAG_W-1:0] eval_flags;
  logic [7:0]        cond_vec;
  logic [3:0]        mux_s1;
  logic [1:0]        mux_s2;

  zero_detect8 u_zero_detect (
    .data (result),
    .zero (zero_det)
  );

  assign zero_now = zero_det;

  // Chained updates AND into the held Z so one nonzero byte poisons the word.
  assign upd_val[FLAG_Z] = chain ? (flags_reg[FLAG_Z] & zero_det) : zero_det;
  assign upd_val[FLAG_N] = result[7];
  assign upd_val[FLAG_C] = carry_in;
  assign upd_val[FLAG_V] = ovf_in;

  genvar gi;
  generate
    for (gi = 0; gi < FLAG_W; gi++) begin : g_flag_mux
      assign flags_next[gi] = load   ? load_data[gi] :
                              update ? upd_val[gi]   :
                                       flags_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_reg <= RESET_FLAGS;
    end else begin
      flags_reg <= flags_next;
    end
  end

  assign flags = flags_reg;

  // While reset is asserted the branch logic already sees the reset flags.
  assign eval_flags = rst_n ? flags_reg : RESET_FLAGS;
  assign cond_vec   = cond_table(eval_flags);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_cond_s1
      assign mux_s1[gi] = cond[0] ? cond_vec[2*gi+1] : cond_vec[2*gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_cond_s2
      assign mux_s2[gi] = cond[1] ? mux_s1[2*gi+1] : mux_s1[2*gi];
    end
  endgenerate

  assign cond_true = cond[2] ? mux_s2[1] : mux_s2[0];

endmodule

// File: tb/tb_flag_unit8.sv
// Randomized self-checking bench for flag_unit8 against a flag-level model.
module tb_flag_unit8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] result;
  logic       carry_in;
  logic       ovf_in;
  logic       update;
  logic       chain;
  logic       load;
  logic [3:0] load_data;
  logic [2:0] cond;
  logic [3:0] flags;
  logic       cond_true;
  logic       zero_now;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [3:0] m_flags;   // model {V,C,N,Z}

  always #5 clk = ~clk;

  flag_unit8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .carry_in  (carry_in),
    .ovf_in    (ovf_in),
    .update    (update),
    .chain     (chain),
    .load      (load),
    .load_data (load_data),
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true),
    .zero_now  (zero_now)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_cond(input logic [2:0] c, input logic [3:0] f);
    logic z, n, cy, v;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return cy;
      3'd4:    return !cy;
      3'd5:    return n;
      3'd6:    return v;
      default: return cy && !z;
    endcase
  endfunction

  task automatic drive(input logic [7:0] r, input logic cy, input logic ov,
                       input logic up, input logic ch);
    result = r; carry_in = cy; ovf_in = ov; update = up; chain = ch;
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic cycle();
    logic [3:0] nxt;
    if (!rst_n)      nxt = 4'b0000;
    else if (load)   nxt = load_data;
    else if (update) begin
      nxt[0] = (result == 8'h00) && (chain ? m_flags[0] : 1'b1);
      nxt[1] = result[7];
      nxt[2] = carry_in;
      nxt[3] = ovf_in;
    end else         nxt = m_flags;
    @(posedge clk);
    #1;
    m_flags = nxt;
    txn++;
    $display("txn %0d rst_n=%0b load=%0b upd=%0b chain=%0b res=%02h cond=%0d flags=%04b cond_true=%0b",
             txn, rst_n, load, update, chain, result, cond, flags, cond_true);
    chk("flags", flags, m_flags);
    chk("cond_true", cond_true, model_cond(cond, m_flags));
    chk("zero_now", zero_now, result == 8'h00);
  endtask

  initial begin
    // 1: reset beats load and update
    rst_n = 1'b0; load = 1'b1; load_data = 4'hF; cond = 3'd0;
    drive(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    m_flags = 4'bxxxx;
    cycle();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_always", cond_true, 1'b1);
    cond = 3'd2; #1;
    chk("rst_nz", cond_true, 1'b1);
    rst_n = 1'b1; load = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // 2: single updates
    drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
    chk("upd0_flags", flags, 4'b0101);
    cond = 3'd1; #1; chk("upd0_z", cond_true, 1'b1);
    cond = 3'd7; #1; chk("upd0_hi", cond_true, 1'b0);
    drive(8'h80, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk("upd80_flags", flags, 4'b1110);
    chk("upd80_hi", cond_true, 1'b1);

    // 3: chains
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("chain16_zero", flags[0], 1'b1);
    drive(8'h05, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("chain16_nz", flags[0], 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    drive(8'h01, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("chain32_nz", flags[0], 1'b0);

    // 4: load beats update, then hold; chain alone does nothing
    load = 1'b1; load_data = 4'b1010;
    drive(8'h00, 1'b1, 1'b1, 1'b1, 1'b1); cycle();
    chk("load_prio", flags, 4'b1010);
    load = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    chk("hold", flags, 4'b1010);

    // 5: reset mid-chain
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    rst_n = 1'b0; cycle();
    chk("midrst", flags, 4'b0000);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk("postrst_chain_z", flags[0], 1'b0);

    // 6: zero_now sweep with flags held
    update = 1'b0; chain = 1'b0;
    for (int i = 0; i < 256; i++) begin
      result = 8'(i);
      cond = 3'(i);
      #2;
      chk("sweep_zero_now", zero_now, i == 0);
      chk("sweep_cond", cond_true, model_cond(cond, m_flags));
      if (i % 32 == 0) cycle();
    end

    // Random single-cycle traffic
    for (int i = 0; i < 300; i++) begin
      rst_n     = ($urandom_range(0, 29) != 0);
      load      = ($urandom_range(0, 9) == 0);
      load_data = 4'($urandom);
      cond      = 3'($urandom);
      drive(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end

    // Whole-word check: Z must equal (word == 0) after a byte-serial chain
    rst_n = 1'b1; load = 1'b0;
    for (int w = 0; w < 40; w++) begin
      int nbytes;
      logic [31:0] word;
      logic [7:0]  b;
      nbytes = $urandom_range(1, 4);
      word   = 32'h0;
      for (int k = 0; k < nbytes; k++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        word[8*k +: 8] = b;
        cond = 3'($urandom);
        drive(b, 1'($urandom), 1'($urandom), 1'b1, k != 0);
        cycle();
      end
      chk("word_z", flags[0], word == 32'h0);
      chk("word_n", flags[1], word[8*nbytes-1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_unit8.md
Name: flag_unit8

Overview:
- Consumer end of the ALU result bus: detects an all-zero result, derives the N/C/V flags and latches all four in a flag register.
- Evaluates a 3-bit branch condition against the latched flags.
- Supports chained multi-byte operations: Z stays sticky across bytes, so a 16/24/32-bit result processed 8 bits per cycle yields a correct whole-word Z.
- Sits between the 8-bit ALU datapath and the control/branch logic.

Parameters:
- RESET_FLAGS, 4'b0000, flag register value after reset; bit order {V,C,N,Z}.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- result  input  8  ALU result byte for the current cycle.
- carry_in  input  1  ALU carry-out for the current cycle.
- ovf_in  input  1  ALU signed-overflow for the current cycle.
- update  input  1  latch flags derived from result/carry_in/ovf_in this cycle.
- chain  input  1  with update: AND the new zero detect into the held Z (upper bytes of a multi-byte op).
- load  input  1  overwrite the flag register with load_data (flag restore / pop).
- load_data  input  4  flag value for load, order {V,C,N,Z}.
- cond  input  3  branch condition select.
- flags  output  4  registered flags {V,C,N,Z}.
- cond_true  output  1  combinational result of cond evaluated on the registered flags.
- zero_now  output  1  combinational: result == 8'h00 this cycle, unregistered.

Behaviour:
- Reset: when rst_n=0 at a clk edge, flags <= RESET_FLAGS.
  - Reset overrides load and update.
  - During reset, cond_true reflects RESET_FLAGS.
- Priority at each edge (rst_n=1): load > update > hold.
- load=1: flags <= load_data. update and chain are ignored that cycle.
- update=1, chain=0:
  - Z <= (result==0).
  - N <= result[7].
  - C <= carry_in.
  - V <= ovf_in.
- update=1, chain=1:
  - Z <= Z_old & (result==0).
  - N, C, V as in the unchained case, i.e. they reflect the most-significant byte processed.
- update=0, load=0: flags hold. chain alone has no effect.
- Latency:
  - zero_now is combinational from result.
  - Flags are visible on the flags port one cycle after update.
  - cond_true is combinational from the registered flags and cond, so a branch sees the flags from the previous update.
- cond encoding:
  - 000 always (1)
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 V
  - 111 C & !Z (unsigned higher)
- Multi-byte use: first (least-significant) byte with chain=0, subsequent bytes with chain=1.
  - Final Z=1 iff every byte was zero.
  - A nonzero byte anywhere clears Z permanently for that sequence.
- No internal counters. Chain length is unbounded; only the Z path carries history.
- X-free: all outputs defined from the first edge with rst_n=0.

Decomposition:
- Shared package/constants file:
  - Flag bit indices: FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - The eight COND_* encodings above.
  - Reused by the control decoder.
- Sub-module zero_detect8:
  - 8-input NOR tree from primitive gates (OR tree plus a single inverter), output zero_now.
  - Natural counterpart to the existing constant-zero generator.
- Flag storage: 4 D flip-flops with synchronous active-low reset, plus 3-level muxing (reset/load/update) per bit.
- Condition evaluation: an 8:1 mux built from 2:1 mux stages.

Test Plan:
1. Reset: drive load=1 and update=1 during rst_n=0 -> after edge, flags=4'b0000 and cond_true=1 with cond=000. With cond=010, cond_true=1 (!Z).
2. Single update:
   - result=8'h00, carry_in=1, ovf_in=0, update=1 -> next cycle flags=4'b0101 (C,Z); cond=001 -> 1; cond=111 -> 0.
   - Then result=8'h80, carry_in=1, ovf_in=1 -> flags=4'b1110; cond=111 -> 1.
3. Chain, 16-bit zero: bytes 00 (chain=0) then 00 (chain=1) -> Z=1.
   - Chain with a nonzero low byte: 05 (chain=0) then 00 (chain=1) -> Z=0.
   - 4-byte chain 00,00,01,00 -> Z=0 at end.
4. Priority: load=1 with load_data=4'b1010 and update=1 with result=00 -> flags=4'b1010. Next cycle, update=0 and load=0 -> flags hold 4'b1010.
5. Reset mid-chain: chain sequence 00,00, then rst_n=0 -> flags=RESET_FLAGS. Then 00 with chain=1 -> Z=0, because RESET_FLAGS Z=0 ANDs in.
6. zero_now sweep: all 256 result values -> zero_now=1 only for 8'h00. Flags unchanged with update=0 throughout.
